// File: rtl/uart_pkg.sv
// Shared types and constants for the host-link UART receiver.
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam int UART_BAUD_DIV_DFLT = 34;
    // Samples per 8N1 frame: start, eight data bits, stop.
    localparam int UART_FRAME_BITS    = 10;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchronizer: two metastability flops plus a history flop for
// falling-edge detection. All flops preset high so an idle line is quiet.
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic sync_p0;
    logic sync_p1;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_p0 <= rx;
            sync_p1 <= sync_p0;
            rx_prev <= sync_p1;
        end
    end

    assign rx_s    = sync_p1;
    assign rx_fall = rx_prev & ~sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a ready flag held until acknowledged.
// Optional stop-bit error output enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
`ifdef UART_RX_FRAME_ERR_EN
    output logic       frm_err,
`endif
    output logic       rdy
);

    localparam int BW = $clog2(BAUD_DIV) + 1;

    rx_state_t       state;
    logic [BW-1:0]   baud_cnt;
    logic [BW-1:0]   baud_nxt;
    logic [3:0]      bit_cnt;
    logic [8:0]      shift;
    logic [8:0]      shift_nxt;
    logic            rx_s;
    logic            rx_fall;
    logic            tick;
    logic            done;

    rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (RX),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    // Sample when the counter would reach zero; first sample lands mid start bit.
    assign baud_nxt  = baud_cnt - BW'(1);
    assign tick      = (state == RECV) && (baud_nxt == '0);
    assign shift_nxt = {rx_s, shift[8:1]};
    assign done      = tick && (bit_cnt == 4'(UART_FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frm_err  <= 1'b0;
`endif
        end else begin
            if (clr_rdy) begin
                rdy <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                frm_err <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state    <= RECV;
                        baud_cnt <= BW'(BAUD_DIV / 2);
                        bit_cnt  <= '0;
                        rdy      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                        frm_err  <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    baud_cnt <= tick ? BW'(BAUD_DIV) : baud_nxt;
                    if (tick) begin
                        shift   <= shift_nxt;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    // Completion overrides a same-cycle acknowledge.
                    if (done) begin
                        rx_data <= shift_nxt[7:0];
                        rdy     <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        frm_err <= ~rx_s;
`endif
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: BAUD_DIV=34 and BAUD_DIV=8 instances.
// Exercises frm_err checks when UART_RX_FRAME_ERR_EN is defined.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx34 = 1'b1, rx8 = 1'b1;
    logic       clr34 = 1'b0, clr8 = 1'b0;
    logic [7:0] data34, data8;
    logic       rdy34, rdy8;
    logic       ferr34, ferr8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIV(34)) u_d34 (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx34),
        .clr_rdy (clr34),
        .rx_data (data34),
`ifdef UART_RX_FRAME_ERR_EN
        .frm_err (ferr34),
`endif
        .rdy     (rdy34)
    );

    uart_rx #(.BAUD_DIV(8)) u_d8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx8),
        .clr_rdy (clr8),
        .rx_data (data8),
`ifdef UART_RX_FRAME_ERR_EN
        .frm_err (ferr8),
`endif
        .rdy     (rdy8)
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign ferr34 = 1'b0;
    assign ferr8  = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         clr_at;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drives one frame starting at the next edge (offset 0). Returns the
    // offsets at which rdy was first seen rising and first seen falling.
    task automatic send(input bit s8, input logic [7:0] b, input logic stop,
                        input int clr_at, output int rise, output int fall);
        int         d;
        logic [9:0] fr;
        logic       prev;
        logic       cur;
        d    = s8 ? 8 : 34;
        fr   = {stop, b, 1'b0};
        rise = -1;
        fall = -1;
        prev = s8 ? rdy8 : rdy34;
        for (int k = 0; k < 10; k++) begin
            if (s8) rx8 = fr[k]; else rx34 = fr[k];
            for (int c = 0; c < d; c++) begin
                @(posedge clk);
                @(negedge clk);
                cur = s8 ? rdy8 : rdy34;
                if (rise < 0 && cur && !prev) rise = k * d + c;
                if (fall < 0 && !cur && prev) fall = k * d + c;
                prev = cur;
                if (k * d + c + 1 == clr_at) begin
                    if (s8) clr8 = 1'b1; else clr34 = 1'b1;
                end
                if (k * d + c == clr_at) begin
                    clr8  = 1'b0;
                    clr34 = 1'b0;
                end
            end
        end
        if (s8) rx8 = 1'b1; else rx34 = 1'b1;
    endtask

    task automatic pulse_clr34();
        clr34 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr34 = 1'b0;
    endtask

    vec_t vecs[6];
    int   rise, fall;
    logic [7:0] held;
    logic [7:0] partial;

    initial begin
        // Rise offset from the first start-bit edge: 2 sync + D/2 + 9*D.
        vecs[0] = '{8'hA5, 1'b1, -1,  8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 325, 8'h3C, 1'b0};
        vecs[2] = '{8'h01, 1'b1, -1,  8'h01, 1'b0};
        vecs[3] = '{8'h12, 1'b0, -1,  8'h12, 1'b1};
        vecs[4] = '{8'h80, 1'b1, -1,  8'h80, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, -1,  8'hC3, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy34), 32'd0);
        chk("reset_data", 32'(data34), 32'h00);
        chk("reset_err", 32'(ferr34), 32'd0);
        chk("reset_rdy8", 32'(rdy8), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send(1'b0, vecs[i].b, vecs[i].stop, vecs[i].clr_at, rise, fall);
            chk($sformatf("v%0d_rise", i), 32'(rise), 32'd325);
            chk($sformatf("v%0d_data", i), 32'(data34), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_rdy", i), 32'(rdy34), 32'd1);
`ifdef UART_RX_FRAME_ERR_EN
            chk($sformatf("v%0d_err", i), 32'(ferr34), 32'(vecs[i].exp_err));
`endif
            held = data34;
            pulse_clr34();
            chk($sformatf("v%0d_clr", i), 32'(rdy34), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(data34), 32'(held));
        end

        // Back-to-back frames without acknowledge.
        send(1'b0, 8'h00, 1'b1, -1, rise, fall);
        chk("b2b0_rise", 32'(rise), 32'd325);
        chk("b2b0_data", 32'(data34), 32'h00);
        send(1'b0, 8'hFF, 1'b1, -1, rise, fall);
        chk("b2b1_fall", 32'(fall), 32'd2);
        chk("b2b1_rise", 32'(rise), 32'd325);
        chk("b2b1_data", 32'(data34), 32'hFF);

        // Reset after the 4th data bit of 0x81, line returned to idle with it.
        partial = 8'h81;
        rx34 = 1'b0;
        repeat (34) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx34 = partial[k];
            repeat (33) @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        rx34  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_rdy", 32'(rdy34), 32'd0);
        chk("midrst_data", 32'(data34), 32'h00);
        repeat (400) @(posedge clk);
        @(negedge clk);
        chk("midrst_quiet", 32'(rdy34), 32'd0);
        send(1'b0, 8'h55, 1'b1, -1, rise, fall);
        chk("after_rst_rise", 32'(rise), 32'd325);
        chk("after_rst_data", 32'(data34), 32'h55);

        // Short divisor: 2 + 4 + 72.
        send(1'b1, 8'h6E, 1'b1, -1, rise, fall);
        chk("d8_rise", 32'(rise), 32'd78);
        chk("d8_data", 32'(data8), 32'h6E);
        chk("d8_rdy", 32'(rdy8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the analyzer's host command link. It recovers 8N1 frames from the asynchronous RX line at a fixed clocks-per-bit rate and presents each byte with a ready flag until the command decoder acknowledges it. It sits directly downstream of the host-side serial line, pairs with the transmitter at the same baud divisor, and feeds the command/config state machine.

## Interface
- `BAUD_DIV`, 34, clocks per bit period; even, ≥ 4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `RX`  in  1  asynchronous serial input; idle high, start bit low, LSB first.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`.
- `rx_data`  out  8  last completed byte; held stable until the next frame completes.
- `rdy`  out  1  a byte is waiting in `rx_data`.
- `frm_err`  out  1  stop bit of the last frame sampled low (only with `UART_RX_FRAME_ERR_EN`).

## Operation
- `RX` passes through two sync flops, then a third flop `rx_prev` for edge detect; all three reset to 1.
- A line held low out of reset counts as a start edge (sync flops preset high).
- States: IDLE, RECV.
- IDLE: on falling edge (`rx_prev`=1, synced=0) go to RECV; load baud counter with `BAUD_DIV/2`; clear bit counter.
- RECV: baud counter decrements each clock; on reaching 0 sample synced RX into 9-bit shifter (shift right, new bit into [8]), reload `BAUD_DIV`, increment bit counter.
- 10 samples per frame (start, 8 data, stop); start bit shifts out, leaving data in [7:0], stop in [8].
- After 10th sample: copy shifter [7:0] to `rx_data`, set `rdy`, return to IDLE the same cycle.
- No false-start rejection: a sampled-high start bit still produces a byte.
- `rdy` cleared by `clr_rdy` or by a new start edge; frame completion in the same cycle as `clr_rdy` wins (set).
- New frame while `rdy` high: `rdy` drops at start edge; old byte overwritten on completion (no overrun flag).
- Reset mid-frame: IDLE, partial frame discarded, outputs to reset values.
- Counters: baud counter `$clog2(BAUD_DIV)+1` bits, bit counter 4 bits; neither wraps within a frame.

## Timing
- Reset values: `rx_data`=0x00, `rdy`=0, `frm_err`=0, state IDLE.
- E = clock edge at which edge detect fires. Sample k (0..9) at E + `BAUD_DIV/2` + k·`BAUD_DIV`.
- `rdy` and new `rx_data` visible at E + `BAUD_DIV/2` + 9·`BAUD_DIV` + 1 (default E+324).
- Pin-to-E latency: 2 clocks (synchronizer).
- `clr_rdy` takes effect next edge; `rdy` low one cycle after.
- Back-to-back frames: next start edge detectable from the cycle after the stop sample.

## Configuration
- `UART_RX_FRAME_ERR_EN` defined: `frm_err` port present; on completion `frm_err` <= ~stop sample; cleared with `rdy` (same rules); `rdy` and `rx_data` still delivered.
- Not defined: `frm_err` port absent; stop sample ignored.

## Structure
- Package `uart_pkg`: `rx_state_t` enum (IDLE, RECV), `UART_BAUD_DIV_DFLT` = 34, `UART_FRAME_BITS` = 10.
- Sub-module `rx_sync`: 2-flop synchronizer + `rx_prev` flop, outputs synced level and falling-edge pulse.

## Test plan
- Send 0xA5 at 34 clocks/bit → `rdy` rises E+324, `rx_data`=0xA5; pulse `clr_rdy` → `rdy`=0 next cycle.
- Back-to-back 0x00 then 0xFF, one stop bit, no `clr_rdy` → `rdy` drops at second start, `rx_data`=0xFF after second frame.
- `clr_rdy` asserted in completion cycle of 0x3C → `rdy`=1, `rx_data`=0x3C.
- Assert `rst_n`=0 for one cycle after 4th data bit of 0x81 → `rdy`=0, `rx_data`=0x00, next frame 0x55 received correctly.
- With `UART_RX_FRAME_ERR_EN`: frame 0x12 with stop bit low → `rdy`=1, `rx_data`=0x12, `frm_err`=1; following good frame → `frm_err`=0.
- `BAUD_DIV`=8, send 0x6E → sample points E+4+8k, `rx_data`=0x6E at E+77.
